// File: rtl/pc_predict_unit_pkg.sv
// Shared types for the branch predictor: counter encoding, BTB entry layout, counter update.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// The entry struct is sized for the widest supported PC (BP_MAX_XLEN). Narrower configurations
// zero-extend tag and target into it, so one struct serves every parameterisation.
package bp_pkg;

    localparam int BP_MAX_XLEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    typedef struct packed {
        logic                   valid;
        logic [BP_MAX_XLEN-1:0] tag;
        logic [BP_MAX_XLEN-1:0] target;
        ctr_t                   ctr;
    } bp_entry_t;

    // Two-bit saturating counter step: taken moves toward ST, not-taken toward SNT.
    function automatic ctr_t sat_update(input ctr_t c, input logic taken);
        ctr_t r;
        r = c;
        case (c)
            SNT: r = taken ? WNT : SNT;
            WNT: r = taken ? WT  : SNT;
            WT:  r = taken ? ST  : WNT;
            ST:  r = taken ? ST  : WT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_predict_unit_if.sv
// Fetch/execute-facing bundle of the PC predictor: fetch PC, prediction, resolution, redirect.
// Latency: pred_* and redirect are combinational; pc is registered.
// Backpressure: stall holds the fetch PC; redirect overrides it.
//
// master: the pipeline side (drives stall and res_*); slave: the predictor.
interface pc_predict_unit_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            res_valid;
    logic            res_is_branch;
    logic            res_taken;
    logic [XLEN-1:0] res_pc;
    logic [XLEN-1:0] res_imm;
    logic            res_pred_taken;
    logic [XLEN-1:0] res_pred_target;
    logic            redirect;

    modport master (
        output stall, res_valid, res_is_branch, res_taken, res_pc, res_imm,
               res_pred_taken, res_pred_target,
        input  pc, pred_taken, pred_target, redirect
    );

    modport slave (
        input  stall, res_valid, res_is_branch, res_taken, res_pc, res_imm,
               res_pred_taken, res_pred_target,
        output pc, pred_taken, pred_target, redirect
    );
endinterface

// File: rtl/pc_predict_unit_table.sv
// Direct-mapped BTB/counter storage: async fetch read, read-modify-write training port.
// Latency: reads combinational; writes land at the rising edge, no same-cycle bypass.
// Backpressure: none; a write is accepted every cycle wrEn is high.
//
// Ports: rdIdx/rdEntry fetch lookup; wrIdx/wrOld expose the entry being trained so the
// caller can build the updated copy; wrEn/wrEntry commit it. Reset clears valid and sets
// every counter to WNT; tag/target are cleared too although their reset value is unused.
module bp_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX = $clog2(ENTRIES)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IDX-1:0] rdIdx,
    output bp_entry_t      rdEntry,
    input  logic [IDX-1:0] wrIdx,
    output bp_entry_t      wrOld,
    input  logic           wrEn,
    input  bp_entry_t      wrEntry
);

    bp_entry_t mem [ENTRIES];

    assign rdEntry = mem[rdIdx];
    assign wrOld   = mem[wrIdx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (wrEn) begin
            mem[wrIdx] <= wrEntry;
        end
    end

endmodule

// File: rtl/pc_predict_unit.sv
// Next-PC generator: owns the fetch PC, predicts from a BTB, trains on resolution, redirects.
// Latency: prediction same cycle as pc; redirect combinational, corrected pc one edge later.
// Backpressure: stall holds pc unless a redirect is raised in the same cycle.
//
// Ports: clk, rst_n (async active-low); bus (slave modport) carries stall, pc, pred_taken,
// pred_target, the res_* resolution fields and redirect. bus must be instantiated with the
// same XLEN as this module.
module pc_predict_unit
    import bp_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ENTRIES  = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               rst_n,
    pc_predict_unit_if.slave  bus
);

    localparam int IDX = $clog2(ENTRIES);

    logic [XLEN-1:0] pcQ;
    logic [XLEN-1:0] pcNext;
    logic [XLEN-1:0] seqPc;
    logic [XLEN-1:0] predTarget;
    logic [XLEN-1:0] actualPc;
    logic            predTaken;
    logic            fetchHit;
    logic            resBranch;
    logic            resHit;
    logic            redirect;
    logic            resWrite;
    logic [IDX-1:0]  fetchIdx;
    logic [IDX-1:0]  resIdx;
    bp_entry_t       fetchEntry;
    bp_entry_t       resOld;
    bp_entry_t       resNew;

    // ---------------- fetch-side prediction ----------------
    assign fetchIdx   = pcQ[IDX+1:2];
    assign fetchHit   = fetchEntry.valid &&
                        (fetchEntry.tag == BP_MAX_XLEN'(pcQ[XLEN-1:IDX+2]));
    // Upper counter bit set (WT or ST) means predict taken.
    assign predTaken  = fetchHit && (fetchEntry.ctr inside {WT, ST});
    assign seqPc      = pcQ + XLEN'(4);
    assign predTarget = predTaken ? fetchEntry.target[XLEN-1:0] : seqPc;

    // ---------------- mispredict compare ----------------
    assign resBranch = bus.res_valid && bus.res_is_branch;
    assign actualPc  = bus.res_taken ? (bus.res_pc + bus.res_imm) : (bus.res_pc + XLEN'(4));
    // A wrong direction with a coincidentally equal target still counts as a mispredict so
    // that the travelling prediction bit stays consistent with the trained counter.
    assign redirect  = resBranch &&
                       ((actualPc != bus.res_pred_target) || (bus.res_taken != bus.res_pred_taken));

    // ---------------- training ----------------
    assign resIdx = bus.res_pc[IDX+1:2];
    assign resHit = resOld.valid && (resOld.tag == BP_MAX_XLEN'(bus.res_pc[XLEN-1:IDX+2]));

    always_comb begin
        resWrite = 1'b0;
        resNew   = resOld;
        if (resBranch) begin
            if (resHit) begin
                resWrite   = 1'b1;
                resNew.ctr = sat_update(resOld.ctr, bus.res_taken);
                if (bus.res_taken) begin
                    resNew.target = BP_MAX_XLEN'(actualPc);
                end
            end else if (bus.res_taken) begin
                // Taken miss evicts whatever aliases to this index; not-taken misses are ignored.
                resWrite = 1'b1;
                resNew   = '{valid:  1'b1,
                             tag:    BP_MAX_XLEN'(bus.res_pc[XLEN-1:IDX+2]),
                             target: BP_MAX_XLEN'(actualPc),
                             ctr:    WT};
            end
        end
    end

    bp_table #(
        .ENTRIES (ENTRIES)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdIdx   (fetchIdx),
        .rdEntry (fetchEntry),
        .wrIdx   (resIdx),
        .wrOld   (resOld),
        .wrEn    (resWrite),
        .wrEntry (resNew)
    );

    // ---------------- PC register and next-PC mux ----------------
    always_comb begin
        pcNext = predTarget;
        if (redirect) begin
            pcNext = actualPc;
        end else if (bus.stall) begin
            pcNext = pcQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcQ <= RESET_PC;
        end else begin
            pcQ <= pcNext;
        end
    end

    assign bus.pc          = pcQ;
    assign bus.pred_taken  = predTaken;
    assign bus.pred_target = predTarget;
    assign bus.redirect    = redirect;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: directed scenarios with literal expectations, then random traffic
// checked every cycle against a table-of-entries reference model.
module tb_pc_predict_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pc_predict_unit_if #(.XLEN(32)) bus ();

    pc_predict_unit #(
        .XLEN     (32),
        .ENTRIES  (16),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] mPc;
    logic        mValid [16];
    logic [31:0] mTag   [16];
    logic [31:0] mTgt   [16];
    int          mCtr   [16];

    task automatic model_reset();
        mPc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0;
            mTag[i]   = 32'h0;
            mTgt[i]   = 32'h0;
            mCtr[i]   = 1;
        end
    endtask

    function automatic void predict(input logic [31:0] p, output logic t, output logic [31:0] g);
        int idx;
        idx = int'(p[5:2]);
        t   = mValid[idx] && (mTag[idx] == (p >> 6)) && (mCtr[idx] >= 2);
        g   = t ? mTgt[idx] : p + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model at every falling edge, then advance the model
    // to what must hold after the coming rising edge.
    always @(negedge clk) begin
        logic        eT;
        logic [31:0] eG;
        logic        br;
        logic        eRedir;
        logic [31:0] act;
        int          idx;
        logic        hit;
        if (!rst_n) model_reset();
        predict(mPc, eT, eG);
        br     = bus.res_valid && bus.res_is_branch;
        act    = bus.res_taken ? bus.res_pc + bus.res_imm : bus.res_pc + 32'd4;
        eRedir = br && ((act != bus.res_pred_target) || (bus.res_taken != bus.res_pred_taken));
        chk("cyc_pc", bus.pc, mPc);
        chk("cyc_pred_taken", 32'(bus.pred_taken), 32'(eT));
        chk("cyc_pred_target", bus.pred_target, eG);
        chk("cyc_redirect", 32'(bus.redirect), 32'(eRedir));
        if (br) begin
            idx = int'(bus.res_pc[5:2]);
            hit = mValid[idx] && (mTag[idx] == (bus.res_pc >> 6));
            if (hit) begin
                mCtr[idx] = bus.res_taken ? ((mCtr[idx] == 3) ? 3 : mCtr[idx] + 1)
                                          : ((mCtr[idx] == 0) ? 0 : mCtr[idx] - 1);
                if (bus.res_taken) mTgt[idx] = act;
            end else if (bus.res_taken) begin
                mValid[idx] = 1'b1;
                mTag[idx]   = bus.res_pc >> 6;
                mTgt[idx]   = act;
                mCtr[idx]   = 2;
            end
        end
        if (eRedir)          mPc = act;
        else if (!bus.stall) mPc = eG;
    end

    // ---------------- stimulus helpers ----------------
    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.res_valid       = 1'b0;
        bus.res_is_branch   = 1'b0;
        bus.res_taken       = 1'b0;
        bus.res_pc          = 32'h0;
        bus.res_imm         = 32'h0;
        bus.res_pred_taken  = 1'b0;
        bus.res_pred_target = 32'h0;
    endtask

    task automatic resolve(input logic [31:0] p, input logic [31:0] imm, input logic tk,
                           input logic pt, input logic [31:0] pg);
        bus.res_valid       = 1'b1;
        bus.res_is_branch   = 1'b1;
        bus.res_taken       = tk;
        bus.res_pc          = p;
        bus.res_imm         = imm;
        bus.res_pred_taken  = pt;
        bus.res_pred_target = pg;
    endtask

    // Steer fetch to addr with a mispredicted not-taken branch at addr-4 (allocates nothing).
    task automatic goto(input logic [31:0] addr);
        resolve(addr - 32'd4, 32'h0, 1'b0, 1'b1, addr + 32'h100);
        edge_();
        idle();
        #1;
    endtask

    initial begin
        logic        pt;
        logic [31:0] pg;
        logic [31:0] rp;
        logic [31:0] ri;
        logic        rt;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.stall = 1'b0;
        idle();
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_pred_taken", 32'(bus.pred_taken), 32'h0);
        chk("rst_pred_target", bus.pred_target, 32'h4);
        chk("rst_redirect", 32'(bus.redirect), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk("first_fetch", bus.pc, 32'h0);
        @(posedge clk); #2;
        chk("seq_pc1", bus.pc, 32'h4);
        chk("seq_pred1", 32'(bus.pred_taken), 32'h0);
        @(posedge clk); #2;
        chk("seq_pc2", bus.pc, 32'h8);

        // Taken branch at 0x10 predicted not-taken: allocate, redirect to 0x50.
        resolve(32'h10, 32'h40, 1'b1, 1'b0, 32'h14);
        #1 chk("alloc_redirect", 32'(bus.redirect), 32'h1);
        edge_(); idle(); #1;
        chk("alloc_pc", bus.pc, 32'h50);
        goto(32'h10);
        chk("alloc_pred_taken", 32'(bus.pred_taken), 32'h1);
        chk("alloc_pred_target", bus.pred_target, 32'h50);

        // Not-taken twice: WT -> WNT (redirect to 0x14) -> SNT (correct, no redirect).
        resolve(32'h10, 32'h40, 1'b0, 1'b1, 32'h50);
        #1 chk("nt1_redirect", 32'(bus.redirect), 32'h1);
        edge_(); idle(); #1;
        chk("nt1_pc", bus.pc, 32'h14);
        goto(32'h10);
        chk("nt1_pred_taken", 32'(bus.pred_taken), 32'h0);
        chk("nt1_pred_target", bus.pred_target, 32'h14);
        resolve(32'h10, 32'h40, 1'b0, 1'b0, 32'h14);
        #1 chk("nt2_redirect", 32'(bus.redirect), 32'h0);
        edge_(); idle();
        // From SNT one taken step reaches only WNT, so still predicted not-taken.
        resolve(32'h10, 32'h40, 1'b1, 1'b0, 32'h14);
        #1 chk("snt_taken_redirect", 32'(bus.redirect), 32'h1);
        edge_(); idle(); #1;
        goto(32'h10);
        chk("snt_taken_pred", 32'(bus.pred_taken), 32'h0);

        // Four taken saturate at ST; one not-taken -> WT (taken), second -> WNT.
        repeat (4) begin
            resolve(32'h10, 32'h40, 1'b1, 1'b1, 32'h50);
            edge_();
        end
        resolve(32'h10, 32'h40, 1'b0, 1'b1, 32'h50);
        edge_(); idle(); #1;
        goto(32'h10);
        chk("sat_minus1_pred", 32'(bus.pred_taken), 32'h1);
        chk("sat_minus1_target", bus.pred_target, 32'h50);
        resolve(32'h10, 32'h40, 1'b0, 1'b1, 32'h50);
        edge_(); idle(); #1;
        goto(32'h10);
        chk("sat_minus2_pred", 32'(bus.pred_taken), 32'h0);

        // Redirect overrides stall; stall alone holds pc.
        bus.stall = 1'b1;
        resolve(32'h20, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h24);
        #1 chk("stall_redirect", 32'(bus.redirect), 32'h1);
        edge_(); idle(); #1;
        chk("stall_redirect_pc", bus.pc, 32'h18);
        edge_(); #1;
        chk("stall_hold_pc", bus.pc, 32'h18);
        bus.stall = 1'b0;

        // Aliasing: 0x50 shares index 4 with 0x10 and evicts it.
        resolve(32'h10, 32'h40, 1'b1, 1'b0, 32'h14);
        edge_(); idle(); #1;
        goto(32'h10);
        chk("alias_pre_pred", 32'(bus.pred_taken), 32'h1);
        resolve(32'h50, 32'h10, 1'b1, 1'b0, 32'h54);
        #1 chk("alias_redirect", 32'(bus.redirect), 32'h1);
        edge_(); idle(); #1;
        chk("alias_pc", bus.pc, 32'h60);
        goto(32'h10);
        chk("alias_old_pred", 32'(bus.pred_taken), 32'h0);
        chk("alias_old_target", bus.pred_target, 32'h14);
        goto(32'h50);
        chk("alias_new_pred", 32'(bus.pred_taken), 32'h1);
        chk("alias_new_target", bus.pred_target, 32'h60);

        // Wrap-around at the top of the address space.
        goto(32'hFFFF_FFFC);
        chk("wrap_seq_target", bus.pred_target, 32'h0);
        edge_(); #1;
        chk("wrap_seq_pc", bus.pc, 32'h0);
        resolve(32'hFFFF_FFFC, 32'h8, 1'b1, 1'b0, 32'h0);
        #1 chk("wrap_br_redirect", 32'(bus.redirect), 32'h1);
        edge_(); idle(); #1;
        chk("wrap_br_pc", bus.pc, 32'h4);

        // Non-branch resolution never redirects.
        resolve(32'h10, 32'h80, 1'b1, 1'b0, 32'h14);
        bus.res_is_branch = 1'b0;
        #1 chk("nonbranch_redirect", 32'(bus.redirect), 32'h0);
        edge_(); idle();

        // ---------------- random phase ----------------
        for (int c = 0; c < 3000; c++) begin
            edge_();
            if (c == 1500) begin
                idle();
                bus.stall = 1'b0;
                rst_n = 1'b0;
                #1 chk("midrun_reset_pc", bus.pc, 32'h0);
            end else if (c == 1502) begin
                @(negedge clk);
                #1 rst_n = 1'b1;
            end else if (c != 1501) begin
                bus.stall = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 8))
                    0: rp = 32'h10;
                    1: rp = 32'h50;
                    2: rp = 32'h90;
                    3: rp = 32'h20;
                    4: rp = 32'h24;
                    5: rp = 32'h100;
                    6: rp = 32'hFFFF_FFFC;
                    7: rp = 32'h3C;
                    default: rp = $urandom;
                endcase
                ri = ($urandom_range(0, 63) * 4) - 128;
                rt = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 1) == 1) begin
                    predict(rp, pt, pg);
                end else begin
                    pt = $urandom_range(0, 1) == 1;
                    case ($urandom_range(0, 2))
                        0: pg = rp + 32'd4;
                        1: pg = rp + ri;
                        default: pg = $urandom;
                    endcase
                end
                resolve(rp, ri, rt, pt, pg);
                bus.res_valid     = $urandom_range(0, 1) == 1;
                bus.res_is_branch = $urandom_range(0, 4) != 0;
            end
        end
        edge_();
        idle();
        repeat (2) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Parametrised next-PC generator with a direct-mapped branch target buffer (BTB) and per-entry 2-bit saturating direction counters. It replaces the purely combinational PC+imm/PC+4 selector. It owns the fetch PC register, predicts taken branches at fetch, accepts branch resolution from execute, trains the tables, and redirects fetch on mispredict. It sits between the fetch stage (consumer of `pc`) and the execute stage (producer of `res_*`).

## Interface
Parameters:
- `XLEN`, 32: PC/immediate width.
- `ENTRIES`, 16: BTB/counter entries; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold fetch PC.
- `pc` out XLEN: current fetch PC (registered).
- `pred_taken` out 1: prediction for `pc`.
- `pred_target` out XLEN: predicted next PC for `pc` (BTB target if `pred_taken`, else `pc`+4).
- `res_valid` in 1: a resolution is presented this cycle.
- `res_is_branch` in 1: the resolved instruction is a conditional branch.
- `res_taken` in 1: execute's branch outcome.
- `res_pc` in XLEN: PC of the resolved instruction.
- `res_imm` in XLEN: sign-extended branch offset.
- `res_pred_taken` in 1: `pred_taken` that travelled with the instruction.
- `res_pred_target` in XLEN: `pred_target` that travelled with the instruction.
- `redirect` out 1: mispredict detected; fetch must flush younger instructions.

## Operation
- Index: `IDX = log2(ENTRIES)` bits taken from `pc[IDX+1:2]`. Tag: `pc[XLEN-1:IDX+2]`.
- Per entry: `valid`, `tag`, `target` (XLEN), `ctr` (2 bits).
- Hit: `valid` is set and `tag` matches. `pred_taken` = hit && `ctr[1]`.
- Resolution, active when `res_valid && res_is_branch`:
  - `actual` = `res_taken` ? `res_pc+res_imm` : `res_pc+4`.
  - `redirect` = (`actual` != `res_pred_target`) || (`res_taken` != `res_pred_taken`).
- `redirect` is 0 whenever `res_valid` is 0 or `res_is_branch` is 0.
- Next-PC priority:
  1. `redirect`: next PC is `actual`, and this overrides `stall`.
  2. `stall`: hold PC.
  3. Otherwise: next PC is `pred_target`.
- Training, on every valid branch resolution:
  - Counter update: taken increments saturating at 3; not-taken decrements saturating at 0.
  - Allocation on tag miss and `res_taken`: write `valid`, `tag`, `target`=`actual`, and `ctr`=2'b10.
  - A not-taken miss allocates nothing.
  - On a taken hit, `target` is rewritten with `actual`.
- All arithmetic is modulo 2^XLEN. Wrap-around at the top of the address space is legal and produces no flag.

## Timing
- Reset values (asynchronous): `pc`=RESET_PC, all `valid`=0, all `ctr`=2'b01, `redirect`=0, `pred_taken`=0, `pred_target`=RESET_PC+4. `tag` and `target` contents are don't-care.
- `pred_taken` and `pred_target` are combinational from the `pc` register and table state, so they are valid in the same cycle as `pc`.
- `redirect` is combinational from the `res_*` inputs. The corrected `pc` appears after the next rising edge, giving a redirect penalty of 1 cycle.
- Table writes take effect at the rising edge.
- Same-cycle read and write to one index: the read returns the old contents. There is no bypass.
- `rst_n` asserted mid-operation: state clears immediately. The first fetch after release is RESET_PC.
- `res_valid` with `res_is_branch`=0: no table change and no redirect.

## Structure
- Package `bp_pkg`:
  - counter encodings: SNT=0, WNT=1, WT=2, ST=3.
  - `ctr_t` typedef.
  - `bp_entry_t` struct: valid, tag, target, ctr.
  - `sat_update` function.
- Sub-module `bp_table`: storage array with one asynchronous read port, one synchronous write port, and asynchronous reset of `valid`/`ctr`.
- Top level `pc_predict_unit` holds:
  - PC register
  - next-PC mux
  - mispredict compare
  - training logic

## Test plan
- Reset release with `stall`=0 and no resolutions: `pc` sequence 0x0, 0x4, 0x8; `pred_taken`=0 throughout.
- Branch at 0x10, imm=0x40, taken, predicted not-taken (res_pred_target=0x14): `redirect`=1, next `pc`=0x50. Entry allocated with ctr=WT; the next fetch of 0x10 gives `pred_taken`=1, `pred_target`=0x50.
- Same branch resolved not-taken twice after allocation: first resolution gives redirect to 0x14 and ctr=WNT; the next fetch of 0x10 predicts not-taken. Second resolution, correctly predicted, gives `redirect`=0 and ctr=SNT.
- Four consecutive taken resolutions: ctr saturates at ST. One not-taken gives WT, and the prediction stays taken.
- `stall`=1 together with a mispredict at res_pc=0x20, imm=-8: `pc` becomes 0x18 despite the stall. `stall` alone holds `pc`.
- Aliasing with ENTRIES=16: a branch at 0x10 allocated, then a taken branch at 0x50 (same index, different tag). 0x50 replaces the entry, and a fetch of 0x10 then misses with `pred_taken`=0.
